// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchronized serial input, falling-edge start detection,
// mid-bit sampling from a fixed prescaler, optional parity and stop checking.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_data,
    input  logic                  parity_en,
    input  logic                  parity_type,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic                  busy
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(PRESCALE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic                    sync1_q, sync1_d;
    logic                    rx_s_q, rx_s_d;
    logic                    prev_rx_q, prev_rx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    par_en_q, par_en_d;
    logic                    par_type_q, par_type_d;
    logic                    par_err_q, par_err_d;
    logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
    logic                    data_valid_q, data_valid_d;
    logic                    parity_error_q, parity_error_d;
    logic                    stop_error_q, stop_error_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            sync1_q        <= 1'b1;
            rx_s_q         <= 1'b1;
            prev_rx_q      <= 1'b1;
            cnt_q          <= '0;
            idx_q          <= '0;
            shift_q        <= '0;
            par_en_q       <= 1'b0;
            par_type_q     <= 1'b0;
            par_err_q      <= 1'b0;
            p_data_q       <= '0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            rx_s_q         <= rx_s_d;
            prev_rx_q      <= prev_rx_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            shift_q        <= shift_d;
            par_en_q       <= par_en_d;
            par_type_q     <= par_type_d;
            par_err_q      <= par_err_d;
            p_data_q       <= p_data_d;
            data_valid_q   <= data_valid_d;
            parity_error_q <= parity_error_d;
            stop_error_q   <= stop_error_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        sync1_d        = s_data;
        rx_s_d         = sync1_q;
        prev_rx_d      = rx_s_q;
        cnt_d          = cnt_q + CNT_W'(1);
        idx_d          = idx_q;
        shift_d        = shift_q;
        par_en_d       = par_en_q;
        par_type_d     = par_type_q;
        par_err_d      = par_err_q;
        p_data_d       = p_data_q;
        data_valid_d   = 1'b0;
        parity_error_d = 1'b0;
        stop_error_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // A low line after a stop error is not a new start until it goes high again.
                if (!rx_s_q && prev_rx_q) begin
                    state_d    = S_START;
                    par_en_d   = parity_en;
                    par_type_d = parity_type;
                    par_err_d  = 1'b0;
                    idx_d      = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d     = '0;
                    par_err_d = rx_s_q != ((^shift_q) ^ par_type_q);
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d          = '0;
                    state_d        = S_IDLE;
                    p_data_d       = shift_q;
                    data_valid_d   = rx_s_q && !par_err_q;
                    parity_error_d = par_err_q;
                    stop_error_d   = !rx_s_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign p_data       = p_data_q;
    assign data_valid   = data_valid_q;
    assign parity_error = parity_error_q;
    assign stop_error   = stop_error_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a bit-banged transmitter drives s_data and a
// negedge monitor logs busy per cycle plus every strobe with its cycle stamp.
module tb_uart_rx;

    localparam int P    = 8;
    localparam int MAXC = 20000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_data = 1'b1;
    logic       parity_en = 1'b0;
    logic       parity_type = 1'b0;
    logic [7:0] p_data;
    logic       data_valid, parity_error, stop_error, busy;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       dv;
        logic       pe;
        logic       se;
    } ev_t;

    ev_t        ev_q[$];
    logic [7:0] exp_q[$];
    logic       busy_hist [0:MAXC-1];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    uart_rx #(.DATA_WIDTH(8), .PRESCALE(P)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .parity_en    (parity_en),
        .parity_type  (parity_type),
        .p_data       (p_data),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .stop_error   (stop_error),
        .busy         (busy)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor
    always @(negedge clk) begin
        ev_t e;
        if (cyc < MAXC) busy_hist[cyc] = busy;
        if (data_valid || parity_error || stop_error) begin
            e.cyc  = cyc;
            e.data = p_data;
            e.dv   = data_valid;
            e.pe   = parity_error;
            e.se   = stop_error;
            ev_q.push_back(e);
        end
    end

    // Driver tasks: called aligned to posedge+1, and return aligned the same way.
    task automatic drive_bits(input logic v, input int n);
        s_data = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                              input logic stop_v, output int c0);
        c0 = cyc;
        drive_bits(1'b0, P);
        for (int i = 0; i < 8; i++) drive_bits(d[i], P);
        if (pen) drive_bits(pbit, P);
        drive_bits(stop_v, P);
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (p_data !== 8'h00) begin n_bad++; $display("FAIL reset_p_data got %h exp 00", p_data); end
        n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_dv got %b exp 0", data_valid); end
        n_cmp++; if (parity_error !== 1'b0) begin n_bad++; $display("FAIL reset_pe got %b exp 0", parity_error); end
        n_cmp++; if (stop_error !== 1'b0) begin n_bad++; $display("FAIL reset_se got %b exp 0", stop_error); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy); end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        drive_bits(1'b1, 10);
        n_cmp++; if (ev_q.size() !== 0) begin n_bad++; $display("FAIL reset_idle_events got %0d exp 0", ev_q.size()); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_no_parity();
        int c0;
        int bad_busy;
        ev_q.delete();
        parity_en = 1'b0;
        @(posedge clk); #1;
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, c0);
        drive_bits(1'b1, 4);
        n_cmp++; if (ev_q.size() !== 1) begin n_bad++; $display("FAIL np_events got %0d exp 1", ev_q.size()); end
        if (ev_q.size() == 1) begin
            n_cmp++; if (ev_q[0].cyc !== c0 + 79) begin n_bad++; $display("FAIL np_strobe_cycle got %0d exp %0d", ev_q[0].cyc, c0 + 79); end
            n_cmp++; if (ev_q[0].data !== 8'h55) begin n_bad++; $display("FAIL np_data got %h exp 55", ev_q[0].data); end
            n_cmp++; if (ev_q[0].dv !== 1'b1) begin n_bad++; $display("FAIL np_dv got %b exp 1", ev_q[0].dv); end
            n_cmp++; if ({ev_q[0].pe, ev_q[0].se} !== 2'b00) begin n_bad++; $display("FAIL np_err got %b%b exp 00", ev_q[0].pe, ev_q[0].se); end
        end
        n_cmp++; if (busy_hist[c0 + 2] !== 1'b0) begin n_bad++; $display("FAIL np_busy_t0 got %b exp 0", busy_hist[c0 + 2]); end
        bad_busy = 0;
        for (int c = c0 + 3; c <= c0 + 78; c++) if (busy_hist[c] !== 1'b1) bad_busy++;
        n_cmp++; if (bad_busy !== 0) begin n_bad++; $display("FAIL np_busy_window got %0d low cycles exp 0", bad_busy); end
        n_cmp++; if (busy_hist[c0 + 79] !== 1'b0) begin n_bad++; $display("FAIL np_busy_fall got %b exp 0", busy_hist[c0 + 79]); end
    endtask

    task automatic test_parity();
        int c0;
        ev_q.delete();
        parity_en = 1'b1;
        parity_type = 1'b0;
        @(posedge clk); #1;
        send_frame(8'hA2, 1'b1, 1'b1, 1'b1, c0);
        drive_bits(1'b1, 4);
        parity_type = 1'b1;
        send_frame(8'hA2, 1'b1, 1'b1, 1'b1, c0);
        drive_bits(1'b1, 4);
        n_cmp++; if (ev_q.size() !== 2) begin n_bad++; $display("FAIL par_events got %0d exp 2", ev_q.size()); end
        if (ev_q.size() == 2) begin
            n_cmp++; if ({ev_q[0].dv, ev_q[0].pe, ev_q[0].se} !== 3'b100) begin n_bad++; $display("FAIL par_even_flags got %b%b%b exp 100", ev_q[0].dv, ev_q[0].pe, ev_q[0].se); end
            n_cmp++; if (ev_q[0].data !== 8'hA2) begin n_bad++; $display("FAIL par_even_data got %h exp a2", ev_q[0].data); end
            n_cmp++; if ({ev_q[1].dv, ev_q[1].pe, ev_q[1].se} !== 3'b010) begin n_bad++; $display("FAIL par_odd_flags got %b%b%b exp 010", ev_q[1].dv, ev_q[1].pe, ev_q[1].se); end
            n_cmp++; if (ev_q[1].data !== 8'hA2) begin n_bad++; $display("FAIL par_odd_data got %h exp a2", ev_q[1].data); end
            n_cmp++; if (ev_q[1].cyc !== c0 + 87) begin n_bad++; $display("FAIL par_strobe_cycle got %0d exp %0d", ev_q[1].cyc, c0 + 87); end
        end
    endtask

    task automatic test_stop_error();
        int c0;
        int c1;
        int bad_busy;
        ev_q.delete();
        parity_en = 1'b0;
        @(posedge clk); #1;
        send_frame(8'hAA, 1'b0, 1'b0, 1'b0, c0);
        drive_bits(1'b0, 30);
        n_cmp++; if (ev_q.size() !== 1) begin n_bad++; $display("FAIL se_events got %0d exp 1", ev_q.size()); end
        if (ev_q.size() == 1) begin
            n_cmp++; if ({ev_q[0].dv, ev_q[0].pe, ev_q[0].se} !== 3'b001) begin n_bad++; $display("FAIL se_flags got %b%b%b exp 001", ev_q[0].dv, ev_q[0].pe, ev_q[0].se); end
            n_cmp++; if (ev_q[0].data !== 8'hAA) begin n_bad++; $display("FAIL se_data got %h exp aa", ev_q[0].data); end
        end
        bad_busy = 0;
        for (int c = c0 + 79; c < cyc; c++) if (busy_hist[c] !== 1'b0) bad_busy++;
        n_cmp++; if (bad_busy !== 0) begin n_bad++; $display("FAIL se_no_restart got %0d busy cycles exp 0", bad_busy); end
        drive_bits(1'b1, 8);
        ev_q.delete();
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, c1);
        drive_bits(1'b1, 4);
        n_cmp++; if (ev_q.size() !== 1) begin n_bad++; $display("FAIL se_recover_events got %0d exp 1", ev_q.size()); end
        if (ev_q.size() == 1) begin
            n_cmp++; if ({ev_q[0].dv, ev_q[0].data} !== {1'b1, 8'h55}) begin n_bad++; $display("FAIL se_recover got dv=%b data=%h exp dv=1 data=55", ev_q[0].dv, ev_q[0].data); end
        end
    endtask

    task automatic test_glitch();
        int c0;
        ev_q.delete();
        @(posedge clk); #1;
        c0 = cyc;
        drive_bits(1'b0, 2);
        drive_bits(1'b1, 100);
        n_cmp++; if (busy_hist[c0 + 3] !== 1'b1) begin n_bad++; $display("FAIL gl_busy_rise got %b exp 1", busy_hist[c0 + 3]); end
        n_cmp++; if (busy_hist[c0 + 6] !== 1'b1) begin n_bad++; $display("FAIL gl_busy_hold got %b exp 1", busy_hist[c0 + 6]); end
        n_cmp++; if (busy_hist[c0 + 7] !== 1'b0) begin n_bad++; $display("FAIL gl_busy_fall got %b exp 0", busy_hist[c0 + 7]); end
        n_cmp++; if (ev_q.size() !== 0) begin n_bad++; $display("FAIL gl_events got %0d exp 0", ev_q.size()); end
    endtask

    task automatic test_reset_mid_frame();
        int c0;
        logic [7:0] d;
        d = 8'hC3;
        ev_q.delete();
        parity_en = 1'b0;
        @(posedge clk); #1;
        drive_bits(1'b0, P);
        for (int i = 0; i < 3; i++) drive_bits(d[i], P);
        drive_bits(d[3], P / 2);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rm_busy_before got %b exp 1", busy); end
        rst = 1'b1;
        s_data = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rm_busy got %b exp 0", busy); end
        n_cmp++; if (p_data !== 8'h00) begin n_bad++; $display("FAIL rm_p_data got %h exp 00", p_data); end
        n_cmp++; if ({data_valid, parity_error, stop_error} !== 3'b000) begin n_bad++; $display("FAIL rm_strobes got %b%b%b exp 000", data_valid, parity_error, stop_error); end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        drive_bits(1'b1, 20);
        n_cmp++; if (ev_q.size() !== 0) begin n_bad++; $display("FAIL rm_events got %0d exp 0", ev_q.size()); end
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, c0);
        drive_bits(1'b1, 4);
        n_cmp++; if (ev_q.size() !== 1) begin n_bad++; $display("FAIL rm_after_events got %0d exp 1", ev_q.size()); end
        if (ev_q.size() == 1) begin
            n_cmp++; if ({ev_q[0].dv, ev_q[0].data} !== {1'b1, 8'h3C}) begin n_bad++; $display("FAIL rm_after got dv=%b data=%h exp dv=1 data=3c", ev_q[0].dv, ev_q[0].data); end
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        int c_first;
        logic [7:0] words [3];
        logic [7:0] pbits;
        words = '{8'h01, 8'h80, 8'hFF};
        pbits = 8'b0000_0011;   // even-parity bits for 0x01, 0x80, 0xFF
        ev_q.delete();
        exp_q.delete();
        parity_en = 1'b1;
        parity_type = 1'b0;
        @(posedge clk); #1;
        c_first = cyc;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(words[i]);
            send_frame(words[i], 1'b1, pbits[i], 1'b1, c0);
        end
        drive_bits(1'b1, 4);
        n_cmp++; if (ev_q.size() !== 3) begin n_bad++; $display("FAIL b2b_events got %0d exp 3", ev_q.size()); end
        for (int i = 0; i < 3 && i < ev_q.size(); i++) begin
            n_cmp++;
            if ({ev_q[i].dv, ev_q[i].pe, ev_q[i].se, ev_q[i].data} !== {3'b100, exp_q[i]}) begin
                n_bad++;
                $display("FAIL b2b_word%0d got flags=%b%b%b data=%h exp flags=100 data=%h", i, ev_q[i].dv, ev_q[i].pe, ev_q[i].se, ev_q[i].data, exp_q[i]);
            end
            n_cmp++;
            if (ev_q[i].cyc !== c_first + i * 88 + 87) begin
                n_bad++;
                $display("FAIL b2b_cycle%0d got %0d exp %0d", i, ev_q[i].cyc, c_first + i * 88 + 87);
            end
        end
    endtask

    task automatic test_loopback();
        int c0;
        logic [7:0] words [6];
        words = '{8'h00, 8'hFF, 8'h3C, 8'hC3, 8'h5A, 8'h96};
        ev_q.delete();
        exp_q.delete();
        parity_en = 1'b1;
        parity_type = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(words[i]);
            send_frame(words[i], 1'b1, ~(^words[i]), 1'b1, c0);
        end
        drive_bits(1'b1, 4);
        n_cmp++; if (ev_q.size() !== 6) begin n_bad++; $display("FAIL lb_events got %0d exp 6", ev_q.size()); end
        while (ev_q.size() > 0 && exp_q.size() > 0) begin
            ev_t e;
            logic [7:0] x;
            e = ev_q.pop_front();
            x = exp_q.pop_front();
            n_cmp++;
            if ({e.dv, e.pe, e.se, e.data} !== {3'b100, x}) begin
                n_bad++;
                $display("FAIL lb_word got flags=%b%b%b data=%h exp flags=100 data=%h", e.dv, e.pe, e.se, e.data, x);
            end
        end
    endtask

    initial begin
        test_reset();
        test_no_parity();
        test_parity();
        test_stop_error();
        test_glitch();
        test_reset_mid_frame();
        test_back_to_back();
        test_loopback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
